// File: rtl/vxc_chunk_sequencer.sv
// vxc_chunk_sequencer
//   Sequences one vector-times-constant-add pass across the NO_OF_UNITS-wide
//   datapath. It issues chunk reads to operand memory, strobes datapath operand
//   capture MEM_LAT cycles later, writes each datapath result to result memory
//   in order, and reports completion to the solver FSM.
//
// Optional feature:
//   VXC_SEQ_PERF_EN  adds the cycle_count output (busy-cycle counter of the
//                    most recent pass).
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high
//   start         begin a pass; only sampled while idle
//   total         element count; latched on an accepted start
//   busy          pass in progress (issuing reads or draining results)
//   rd_en/rd_addr operand memory chunk read
//   dp_load       datapath operand capture strobe
//   dp_valid_out  datapath result valid, one pulse per chunk
//   wr_en/wr_addr result memory chunk write
//   finish        pass complete; held until the next accepted start
//   err           sticky: a datapath result arrived when none was expected
//   cycle_count   busy cycles of the last pass (VXC_SEQ_PERF_EN only)
module vxc_chunk_sequencer #(
  parameter int unsigned NO_OF_UNITS = 8,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned MEM_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           total,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  dp_load,
  input  logic                  dp_valid_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  finish,
  output logic                  err
`ifdef VXC_SEQ_PERF_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        chunks_q;
  logic [31:0]        rd_cnt;
  logic [31:0]        wr_cnt;
  logic [31:0]        res_cnt;
  logic [MEM_LAT-1:0] ld_sr;

  logic [31:0] start_chunks;
  logic        start_acc;
  logic        res_ok;

  // Quotient plus a remainder flag avoids overflow of total+NO_OF_UNITS-1.
  assign start_chunks = (total / NO_OF_UNITS) + 32'((total % NO_OF_UNITS) != 32'd0);
  assign start_acc    = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (start_chunks == 32'd0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (rd_cnt == chunks_q - 32'd1) state_d = S_DRAIN;
      S_DRAIN: if (wr_cnt == chunks_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign rd_en   = (state_q == S_ISSUE);
  assign rd_addr = rd_cnt[ADDR_WIDTH-1:0];
  assign wr_addr = wr_cnt[ADDR_WIDTH-1:0];
  assign dp_load = ld_sr[MEM_LAT-1];

  // Results are counted on arrival rather than on write so back-to-back
  // pulses are judged against what is already in flight to the write port.
  assign res_ok = dp_valid_out && busy && (res_cnt != chunks_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      chunks_q <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      res_cnt  <= '0;
      ld_sr    <= '0;
      wr_en    <= 1'b0;
      finish   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        chunks_q <= start_chunks;
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        res_cnt  <= '0;
        finish   <= 1'b0;
      end else begin
        if (rd_en)  rd_cnt  <= rd_cnt + 32'd1;
        if (wr_en)  wr_cnt  <= wr_cnt + 32'd1;
        if (res_ok) res_cnt <= res_cnt + 32'd1;
        if (state_q == S_DONE) finish <= 1'b1;
      end
      wr_en <= res_ok;
      if (dp_valid_out && !res_ok) err <= 1'b1;
      ld_sr[0] <= rd_en;
      for (int unsigned i = 1; i < MEM_LAT; i++) ld_sr[i] <= ld_sr[i-1];
    end
  end

`ifdef VXC_SEQ_PERF_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (reset)          cyc_q <= '0;
    else if (start_acc) cyc_q <= '0;
    else if (busy)      cyc_q <= cyc_q + 32'd1;
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_vxc_chunk_sequencer.sv
// Scoreboard bench for vxc_chunk_sequencer: expected read, load and write
// events (cycle and address) are queued when a pass is started; a negedge
// monitor pops and compares them as the DUT presents strobes.
module tb_vxc_chunk_sequencer;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned ML = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   total;
  logic          busy, rd_en, dp_load, wr_en, finish, err;
  logic          dp_valid_out = 1'b0;
  logic [AW-1:0] rd_addr, wr_addr;
`ifdef VXC_SEQ_PERF_EN
  logic [31:0]   cycle_count;
`endif

  vxc_chunk_sequencer #(.NO_OF_UNITS(N), .ADDR_WIDTH(AW), .MEM_LAT(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .total(total), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .dp_load(dp_load),
    .dp_valid_out(dp_valid_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .finish(finish), .err(err)
`ifdef VXC_SEQ_PERF_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tot_n = 0;
  int bad_n = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tot_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct { int unsigned cyc; int unsigned addr; } ev_t;
  ev_t         q_rd[$];
  ev_t         q_wr[$];
  int unsigned q_ld[$];
  bit          mon_en = 1'b0;
  int unsigned busy_cnt = 0;

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && !reset) begin
      if (busy) busy_cnt++;
      if (rd_en) begin
        if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = q_rd.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", rd_addr, e.addr);
        end
      end
      if (dp_load) begin
        if (q_ld.size() == 0) chk("load_unexpected", 1, 0);
        else chk("load_cycle", cyc, q_ld.pop_front());
      end
      if (wr_en) begin
        if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = q_wr.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", wr_addr, e.addr);
        end
      end
    end
  end

  // Datapath model: one result dp_lat cycles after each operand load.
  int unsigned dp_lat = 3;
  int unsigned fire_q[$];
  bit          inject = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      fire_q.delete();
      dp_valid_out = 1'b0;
    end else begin
      if (dp_load) fire_q.push_back(cyc + dp_lat);
      dp_valid_out = inject;
      if (fire_q.size() != 0 && fire_q[0] == cyc) begin
        void'(fire_q.pop_front());
        dp_valid_out = 1'b1;
      end
    end
  end

  task automatic run_pass(input int unsigned tot, input int unsigned lat,
                          input bit expect_err0, input bit poke_drain);
    longint unsigned t64 = tot;
    longint unsigned c   = (t64 + N - 1) / N;
    int unsigned a, n;
    bit poked = 1'b0;
    dp_lat = lat;
    @(negedge clk);
    a = cyc + 1;
    for (longint unsigned i = 0; i < c; i++) begin
      q_rd.push_back('{a + int'(i), int'(i % (1 << AW))});
      q_ld.push_back(a + int'(i) + ML);
      q_wr.push_back('{a + int'(i) + ML + lat + 1, int'(i % (1 << AW))});
    end
    busy_cnt = 0;
    start = 1'b1;
    total = tot;
    @(negedge clk);
    start = 1'b0;
    total = $urandom;
    chk("finish_cleared", finish, 0);
    n = 0;
    while (!finish && n < int'(c) + 100) begin
      if (poke_drain && !poked && busy && !rd_en) begin
        start = 1'b1;
        total = 32'd640;
        poked = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("finish_seen", finish, 1);
    if (c == 0) begin
      chk("zero_finish_cycle", cyc, a + 1);
      chk("zero_busy_cycles", busy_cnt, 0);
    end
    chk("busy_after_finish", busy, 0);
    chk("queues_drained", q_rd.size() + q_ld.size() + q_wr.size(), 0);
    if (expect_err0) chk("err_clear", err, 0);
`ifdef VXC_SEQ_PERF_EN
    chk("cycle_count", cycle_count, busy_cnt);
`endif
    repeat (3) @(negedge clk);
    chk("finish_held", finish, 1);
`ifdef VXC_SEQ_PERF_EN
    chk("cycle_count_frozen", cycle_count, busy_cnt);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    bit any;
    reset = 1'b1;
    start = 1'b0;
    total = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, rd_en, dp_load, wr_en, finish, err, rd_addr, wr_addr}, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    run_pass(64, 3, 1, 0);
    run_pass(13, 3, 1, 0);
    run_pass(0, 3, 1, 0);
    run_pass(1, 1, 1, 0);
    run_pass(8, 4, 1, 0);
    run_pass(9, 2, 1, 0);
    for (int k = 0; k < 6; k++) run_pass($urandom_range(0, 300), $urandom_range(1, 5), 1, 0);
    run_pass(8 * 1030 - 3, 3, 1, 0);

    // Reset in the middle of issue.
    mon_en = 1'b0;
    dp_lat = 3;
    @(negedge clk);
    start = 1'b1;
    total = 32'd64;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rd_en && rd_addr == 3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("saw_rd_addr3", rd_en && rd_addr == 3, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midpass_reset_outputs", {busy, rd_en, dp_load, wr_en, finish, err, rd_addr, wr_addr}, 0);
    @(negedge clk);
    reset = 1'b0;
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any = any | rd_en | wr_en | dp_load | busy;
    end
    chk("quiet_after_reset", any, 0);
    q_rd.delete();
    q_ld.delete();
    q_wr.delete();
    mon_en = 1'b1;
    run_pass(16, 3, 1, 0);

    // Start during drain is ignored; a stray result sets err without a write.
    run_pass(16, 3, 1, 1);
    @(posedge clk);
    inject = 1'b1;
    @(posedge clk);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    run_pass(24, 2, 0, 0);
    chk("err_still_set", err, 1);

    $display("test done: total=%0d bad=%0d", tot_n, bad_n);
    $finish;
  end
endmodule
